// File: rtl/stopwatch_pkg.sv
// Shared constants and digit-modulus helper for the BCD stopwatch/countdown timer.
// Digit order LSB->MSB: fraction digits (mod 10), sec1 (mod 10), sec10 (mod 6), minute digits (mod 10).
package stopwatch_pkg;

  localparam int BCD_W     = 4;
  localparam int MOD_DEC   = 10;
  localparam int MOD_SEC10 = 6;

  // Only the tens-of-seconds digit rolls over at 6; every other digit is decimal.
  function automatic int digit_mod(input int k, input int frac_digits);
    return (k == frac_digits + 1) ? MOD_SEC10 : MOD_DEC;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_timer_if.sv
// Control/status bundle between the timer and its user (display mux, controller).
// ND is the total digit count: FRAC_DIGITS + 2 + MIN_DIGITS.
interface stopwatch_bcd_timer_if #(
  parameter int ND = 4
);
  localparam int W = stopwatch_pkg::BCD_W * ND;

  logic         set;
  logic [W-1:0] preset_bcd;
  logic         pause;
  logic         up;
  logic         lap;
  logic [W-1:0] bcd;
  logic         minus_flag;
  logic         tc_pulse;
  logic [W-1:0] lap_bcd;
  logic         lap_valid;

  modport master (
    output set, preset_bcd, pause, up, lap,
    input  bcd, minus_flag, tc_pulse, lap_bcd, lap_valid
  );

  modport slave (
    input  set, preset_bcd, pause, up, lap,
    output bcd, minus_flag, tc_pulse, lap_bcd, lap_valid
  );

endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the timer: loadable (with saturation), up/down by MODULUS,
// carry/borrow out only when this digit actually steps across its boundary.
module bcd_digit_cell
  import stopwatch_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] q,
  output logic             carry_out,
  output logic             borrow_out
);

  localparam logic [BCD_W-1:0] MAX = BCD_W'(MODULUS - 1);

  logic             at_max;
  logic             at_zero;
  logic [BCD_W-1:0] load_sat;

  assign at_max     = (q == MAX);
  assign at_zero    = (q == '0);
  assign load_sat   = (load_val > MAX) ? MAX : load_val;
  assign carry_out  = en & up & at_max;
  assign borrow_out = en & ~up & at_zero;

  // NOTE: state registers use non-blocking assignments so every digit samples
  // the pre-edge values of its neighbours, keeping the ripple chain race-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_sat;
    end else if (en) begin
      if (up) q <= at_max  ? '0  : q + 1'b1;
      else    q <= at_zero ? MAX : q - 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_timer.sv
// BCD min:sec stopwatch / countdown timer with built-in tick prescaler and terminal-count pulse.
// Optional lap capture register enabled by defining LAP_CAPTURE_EN.
module stopwatch_bcd_timer
  import stopwatch_pkg::*;
#(
  parameter int FRAC_DIGITS  = 1,
  parameter int MIN_DIGITS   = 1,
  parameter int TICK_DIV     = 5000000,
  parameter int HOLD_AT_ZERO = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  stopwatch_bcd_timer_if.slave       bus
);

  localparam int ND    = FRAC_DIGITS + 2 + MIN_DIGITS;
  localparam int W     = BCD_W * ND;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [W-1:0]     bcd;
  logic [ND:0]      ripple;
  logic [ND-1:0]    carry;
  logic [ND-1:0]    borrow;
  logic             hold_block;
  logic             wrap;
  logic             tc_next;
  logic             minus_flag;
  logic             tc_pulse;

  // Prescaler: pause freezes it mid-period, set restarts the period.
  assign tick = (cnt == CNT_LAST) && !bus.pause;

  always_ff @(posedge clk) begin
    if (reset || bus.set) cnt <= '0;
    else if (tick)        cnt <= '0;
    else if (!bus.pause)  cnt <= cnt + 1'b1;
  end

  // In hold mode a down tick at all-zero is swallowed before it reaches the digits.
  assign hold_block = (HOLD_AT_ZERO != 0) && !bus.up && (bcd == '0);
  assign ripple[0]  = tick && !hold_block;

  for (genvar k = 0; k < ND; k++) begin : g_digit
    bcd_digit_cell #(
      .MODULUS (digit_mod(k, FRAC_DIGITS))
    ) u_cell (
      .clk        (clk),
      .reset      (reset),
      .en         (ripple[k]),
      .up         (bus.up),
      .load       (bus.set),
      .load_val   (bus.preset_bcd[BCD_W*k +: BCD_W]),
      .q          (bcd[BCD_W*k +: BCD_W]),
      .carry_out  (carry[k]),
      .borrow_out (borrow[k])
    );
    assign ripple[k+1] = carry[k] | borrow[k];
  end

  // A ripple out of the top digit is a full-range wrap in either direction.
  assign wrap    = ripple[ND];
  assign tc_next = wrap ||
                   ((HOLD_AT_ZERO != 0) && tick && !bus.up && (bcd == W'(1)));

  always_ff @(posedge clk) begin
    if (reset || bus.set) begin
      minus_flag <= 1'b0;
      tc_pulse   <= 1'b0;
    end else begin
      tc_pulse <= tc_next;
      if (wrap && !bus.up) minus_flag <= 1'b1;
    end
  end

  assign bus.bcd        = bcd;
  assign bus.minus_flag = minus_flag;
  assign bus.tc_pulse   = tc_pulse;

`ifdef LAP_CAPTURE_EN
  logic         lap_q;
  logic [W-1:0] lap_bcd_r;
  logic         lap_valid_r;

  // Captures the count as it stood before this edge, even if a tick lands on it.
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q       <= 1'b0;
      lap_bcd_r   <= '0;
      lap_valid_r <= 1'b0;
    end else begin
      lap_q <= bus.lap;
      if (bus.set) begin
        lap_bcd_r   <= '0;
        lap_valid_r <= 1'b0;
      end else if (bus.lap && !lap_q) begin
        lap_bcd_r   <= bcd;
        lap_valid_r <= 1'b1;
      end
    end
  end

  assign bus.lap_bcd   = lap_bcd_r;
  assign bus.lap_valid = lap_valid_r;
`else
  logic lap_unused;
  assign lap_unused    = bus.lap;
  assign bus.lap_bcd   = '0;
  assign bus.lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_timer.sv
// Self-checking bench: wrap-mode and hold-mode instances driven in lockstep,
// checked against an arithmetic reference model plus a table of fixed vectors.
module tb_stopwatch_bcd_timer;

  localparam int TD = 4;
  localparam int FD = 1;
  localparam int MD = 1;
  localparam int ND = FD + 2 + MD;
  localparam int N  = 10 * 60 * 10;  // tenths in 0:00.0 .. 9:59.9

`ifdef LAP_CAPTURE_EN
  localparam logic [15:0] LAP_EXP   = 16'h0012;
  localparam logic        LAP_V_EXP = 1'b1;
`else
  localparam logic [15:0] LAP_EXP   = 16'h0000;
  localparam logic        LAP_V_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stopwatch_bcd_timer_if #(.ND(ND)) bus0 ();
  stopwatch_bcd_timer_if #(.ND(ND)) bus1 ();

  stopwatch_bcd_timer #(.FRAC_DIGITS(FD), .MIN_DIGITS(MD), .TICK_DIV(TD), .HOLD_AT_ZERO(0))
    u_dut_wrap (.clk(clk), .reset(reset), .bus(bus0));
  stopwatch_bcd_timer #(.FRAC_DIGITS(FD), .MIN_DIGITS(MD), .TICK_DIV(TD), .HOLD_AT_ZERO(1))
    u_dut_hold (.clk(clk), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  bit          in_reset, in_set, in_pause, in_up, in_lap;
  logic [15:0] in_preset;

  typedef struct {
    int          val;
    int          cnt;
    bit          minus;
    bit          tc;
    logic [15:0] lap_bcd;
    bit          lap_valid;
    bit          lap_q;
  } model_t;

  model_t m0, m1;

  typedef struct {
    bit          rst;
    bit          set;
    logic [15:0] preset;
    bit          pause;
    bit          up;
    int          n;
    logic [15:0] e0;
    bit          m0;
    bit          t0;
    logic [15:0] e1;
    bit          m1;
    bit          t1;
  } row_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int s, mins, r;
    s    = v / 10;
    mins = s / 60;
    r    = s % 60;
    return {4'(mins), 4'(r / 10), 4'(r % 10), 4'(v % 10)};
  endfunction

  function automatic int sat(input logic [3:0] d, input int m);
    return (int'(d) > m - 1) ? m - 1 : int'(d);
  endfunction

  function automatic int from_preset(input logic [15:0] p);
    logic [15:0] pv;
    pv = p;
    return sat(pv[3:0], 10) + 10 * (sat(pv[7:4], 10) + 10 * sat(pv[11:8], 6) + 60 * sat(pv[15:12], 10));
  endfunction

  task automatic model_edge(input bit hold, inout model_t s);
    if (in_reset) begin
      s = '{default: 0};
    end else begin
`ifdef LAP_CAPTURE_EN
      if (in_set) begin
        s.lap_bcd   = '0;
        s.lap_valid = 1'b0;
      end else if (in_lap && !s.lap_q) begin
        s.lap_bcd   = to_bcd(s.val);
        s.lap_valid = 1'b1;
      end
`endif
      s.lap_q = in_lap;
      if (in_set) begin
        s.val   = from_preset(in_preset);
        s.minus = 1'b0;
        s.cnt   = 0;
        s.tc    = 1'b0;
      end else if (in_pause) begin
        s.tc = 1'b0;
      end else if (s.cnt == TD - 1) begin
        s.cnt = 0;
        if (in_up) begin
          s.tc  = (s.val == N - 1);
          s.val = (s.val + 1) % N;
        end else if (s.val == 0) begin
          if (hold) s.tc = 1'b0;
          else begin
            s.val   = N - 1;
            s.minus = 1'b1;
            s.tc    = 1'b1;
          end
        end else begin
          s.tc  = hold && (s.val == 1);
          s.val = s.val - 1;
        end
      end else begin
        s.cnt++;
        s.tc = 1'b0;
      end
    end
  endtask

  function automatic logic [63:0] pack_model(input model_t s);
    return 64'({to_bcd(s.val), s.minus, s.tc, s.lap_valid, s.lap_bcd});
  endfunction

  task automatic drive(input bit r, input bit s, input logic [15:0] p,
                       input bit pa, input bit u, input bit l);
    in_reset = r; in_set = s; in_preset = p; in_pause = pa; in_up = u; in_lap = l;
    reset = r;
    bus0.set = s; bus0.preset_bcd = p; bus0.pause = pa; bus0.up = u; bus0.lap = l;
    bus1.set = s; bus1.preset_bcd = p; bus1.pause = pa; bus1.up = u; bus1.lap = l;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(1'b0, m0);
    model_edge(1'b1, m1);
    #1;
    check("model_wrap", 64'({bus0.bcd, bus0.minus_flag, bus0.tc_pulse, bus0.lap_valid, bus0.lap_bcd}),
          pack_model(m0));
    check("model_hold", 64'({bus1.bcd, bus1.minus_flag, bus1.tc_pulse, bus1.lap_valid, bus1.lap_bcd}),
          pack_model(m1));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[9];
    rows[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1,   16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    rows[1] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 160, 16'h0040, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0};
    rows[2] = '{1'b0, 1'b1, 16'h9599, 1'b0, 1'b1, 1,   16'h9599, 1'b0, 1'b0, 16'h9599, 1'b0, 1'b0};
    rows[3] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4,   16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
    rows[4] = '{1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1,   16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
    rows[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4,   16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    rows[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4,   16'h9599, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    rows[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8,   16'h9597, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    rows[8] = '{1'b0, 1'b1, 16'hFA7C, 1'b0, 1'b1, 1,   16'h9579, 1'b0, 1'b0, 16'h9579, 1'b0, 1'b0};

    m0 = '{default: 0};
    m1 = '{default: 0};

    for (int i = 0; i < 9; i++) begin
      drive(rows[i].rst, rows[i].set, rows[i].preset, rows[i].pause, rows[i].up, 1'b0);
      repeat (rows[i].n) cycle();
      check($sformatf("tbl%0d_wrap", i), 64'({bus0.bcd, bus0.minus_flag, bus0.tc_pulse}),
            64'({rows[i].e0, rows[i].m0, rows[i].t0}));
      check($sformatf("tbl%0d_hold", i), 64'({bus1.bcd, bus1.minus_flag, bus1.tc_pulse}),
            64'({rows[i].e1, rows[i].m1, rows[i].t1}));
    end

    // Pause mid-period: count and prescaler freeze, remaining two cycles finish the step.
    drive(1'b0, 1'b1, 16'hFA7C, 1'b0, 1'b1, 1'b0); cycle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0); repeat (2) cycle();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0); repeat (10) cycle();
    check("pause_frozen", 64'(bus0.bcd), 64'(16'h9579));
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0); cycle();
    check("pause_resume_wait", 64'(bus0.bcd), 64'(16'h9579));
    cycle();
    check("pause_resume_step", 64'({bus0.bcd, bus0.tc_pulse}), 64'({16'h9580, 1'b0}));

    // Direction changed mid-period takes effect at the next tick.
    drive(1'b0, 1'b1, 16'h0005, 1'b0, 1'b1, 1'b0); cycle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0); repeat (2) cycle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); repeat (2) cycle();
    check("dir_change", 64'(bus0.bcd), 64'(16'h0004));

    // Lap edge coincident with a tick captures the pre-tick value; held lap does not recapture.
    drive(1'b0, 1'b1, 16'h0012, 1'b0, 1'b1, 1'b0); cycle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0); repeat (3) cycle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1); cycle();
    check("lap_capture", 64'({bus0.bcd, bus0.lap_valid, bus0.lap_bcd}),
          64'({16'h0013, LAP_V_EXP, LAP_EXP}));
    repeat (4) cycle();
    check("lap_no_recapture", 64'({bus0.bcd, bus0.lap_valid, bus0.lap_bcd}),
          64'({16'h0014, LAP_V_EXP, LAP_EXP}));
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0); cycle();
    check("reset_mid_count", 64'({bus0.bcd, bus0.minus_flag, bus0.tc_pulse, bus0.lap_valid, bus0.lap_bcd}),
          64'(0));

    // Randomised traffic against the reference model.
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      bit r, s, pa, u, l;
      r  = ($urandom_range(0, 499) == 0);
      s  = ($urandom_range(0, 63) == 0);
      pa = ($urandom_range(0, 3) == 0);
      u  = (in_up ^ ($urandom_range(0, 15) == 0));
      l  = ($urandom_range(0, 7) == 0);
      drive(r, s, 16'($urandom()), pa, u, l);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
